sfx_sequencer: RTL

Generates the game's sound-effect sample stream and feeds the audio codec write port. It sits directly upstream of the audio output stage. Game logic raises `chomp`, `eatghost` and `death` event lines. The block picks an effect by priority, steps through a fixed note table as square waves, and presents one signed 24-bit sample per codec write slot. Silence is a stream of zero samples, so the codec FIFO never starves.

---
 rtl/sfx_sequencer.sv | 219 +++++++++++++++++++++
 1 files changed

// File: rtl/sfx_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : sfx_sequencer
// Description : Sound-effect generator. It detects rising edges on the
//               chomp/eatghost/death event lines and picks one effect by
//               priority. It plays that effect's notes from a fixed
//               half-period table as +/-AMP square waves. It presents one
//               signed 24-bit sample per codec write slot, and the sample
//               is 0 when idle or between notes.
// Ports       : CLOCK_50    - system clock
//               reset       - synchronous active-high reset
//               chomp       - pellet-eaten event (level, rising edge triggers)
//               eatghost    - ghost-eaten event (level, rising edge triggers)
//               death       - pacman-death event (level, rising edge triggers)
//               write_ready - codec can accept a sample this cycle
//               write       - codec write strobe (write_ready gated by reset)
//               sample      - signed sample for both codec channels
//               busy        - an effect is playing (PLAY or GAP)
//               effect      - 0 none, 1 chomp, 2 eatghost, 3 death
// Revision    : 1.0 - initial release
// ============================================================================
module sfx_sequencer #(
  parameter int AMP      = 40000,
  parameter int NOTE_LEN = 12000,
  parameter int GAP_LEN  = 2400
) (
  input  logic        CLOCK_50,
  input  logic        reset,
  input  logic        chomp,
  input  logic        eatghost,
  input  logic        death,
  input  logic        write_ready,
  output logic        write,
  output logic [23:0] sample,
  output logic        busy,
  output logic [1:0]  effect
);

  localparam int c_MAXLEN = (NOTE_LEN > GAP_LEN) ? NOTE_LEN : GAP_LEN;
  localparam int c_CW     = $clog2(c_MAXLEN + 1);

  localparam logic [1:0] c_IDLE = 2'd0;
  localparam logic [1:0] c_PLAY = 2'd1;
  localparam logic [1:0] c_GAP  = 2'd2;

  localparam logic [c_CW-1:0] c_ONE      = c_CW'(1);
  localparam logic [c_CW-1:0] c_LEN_LAST = c_CW'(NOTE_LEN - 1);
  // Clamped so the constant stays meaningful when GAP_LEN is 0 (GAP unused then).
  localparam logic [c_CW-1:0] c_GAP_LAST = c_CW'(((GAP_LEN > 0) ? GAP_LEN : 1) - 1);
  localparam logic [23:0]     c_POS      = 24'(AMP);
  localparam logic [23:0]     c_NEG      = 24'(-AMP);

  // Note table: half-periods in accepted samples.
  function automatic logic [3:0] half_period(input logic [3:0] idx);
    case (idx)
      4'd0:    half_period = 4'd6;
      4'd1:    half_period = 4'd3;
      4'd2:    half_period = 4'd12;
      4'd3:    half_period = 4'd9;
      4'd4:    half_period = 4'd6;
      4'd5:    half_period = 4'd3;
      4'd6:    half_period = 4'd3;
      4'd7:    half_period = 4'd4;
      4'd8:    half_period = 4'd5;
      4'd9:    half_period = 4'd6;
      4'd10:   half_period = 4'd7;
      4'd11:   half_period = 4'd8;
      4'd12:   half_period = 4'd9;
      4'd13:   half_period = 4'd10;
      default: half_period = 4'd1;
    endcase
  endfunction

  function automatic logic [3:0] base_idx(input logic [1:0] eff);
    case (eff)
      2'd2:    base_idx = 4'd2;
      2'd3:    base_idx = 4'd6;
      default: base_idx = 4'd0;
    endcase
  endfunction

  function automatic logic [3:0] last_idx(input logic [1:0] eff);
    case (eff)
      2'd2:    last_idx = 4'd5;
      2'd3:    last_idx = 4'd13;
      default: last_idx = 4'd1;
    endcase
  endfunction

  logic [1:0]      state_q,  state_d;
  logic [1:0]      effect_q, effect_d;
  logic [3:0]      idx_q,    idx_d;
  logic [3:0]      half_q,   half_d;
  logic [c_CW-1:0] len_q,    len_d;
  logic [c_CW-1:0] gap_q,    gap_d;
  logic            pol_q,    pol_d;
  logic            chomp_q, eatghost_q, death_q;

  logic [1:0] sel;
  logic       start;
  logic       accept;
  logic [3:0] half_last;

  assign accept    = write_ready & ~reset;
  assign half_last = half_period(idx_q) - 4'd1;

  // Highest-priority rising edge this cycle; lower ones are simply dropped.
  assign sel = (death    & ~death_q)    ? 2'd3 :
               (eatghost & ~eatghost_q) ? 2'd2 :
               (chomp    & ~chomp_q)    ? 2'd1 : 2'd0;

  // Starts from IDLE, or preempts only with strictly higher priority. This
  // also covers a trigger that lands on the final accepted sample.
  assign start = (sel != 2'd0) && ((state_q == c_IDLE) || (sel > effect_q));

  // State register
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      state_q    <= c_IDLE;
      effect_q   <= 2'd0;
      idx_q      <= 4'd0;
      half_q     <= 4'd0;
      len_q      <= '0;
      gap_q      <= '0;
      pol_q      <= 1'b0;
      chomp_q    <= 1'b0;
      eatghost_q <= 1'b0;
      death_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      effect_q   <= effect_d;
      idx_q      <= idx_d;
      half_q     <= half_d;
      len_q      <= len_d;
      gap_q      <= gap_d;
      pol_q      <= pol_d;
      chomp_q    <= chomp;
      eatghost_q <= eatghost;
      death_q    <= death;
    end
  end

  // Next-state logic
  always_comb begin
    state_d  = state_q;
    effect_d = effect_q;
    idx_d    = idx_q;
    half_d   = half_q;
    len_d    = len_q;
    gap_d    = gap_q;
    pol_d    = pol_q;
    if (start) begin
      state_d  = c_PLAY;
      effect_d = sel;
      idx_d    = base_idx(sel);
      half_d   = 4'd0;
      len_d    = '0;
      gap_d    = '0;
      pol_d    = 1'b1;
    end else if (accept) begin
      case (state_q)
        c_PLAY: begin
          if (half_q == half_last) begin
            half_d = 4'd0;
            pol_d  = ~pol_q;
          end else begin
            half_d = half_q + 4'd1;
          end
          len_d = len_q + c_ONE;
          if (len_q == c_LEN_LAST) begin
            if (idx_q == last_idx(effect_q)) begin
              state_d  = c_IDLE;
              effect_d = 2'd0;
              idx_d    = 4'd0;
              half_d   = 4'd0;
              len_d    = '0;
              pol_d    = 1'b0;
            end else if (GAP_LEN == 0) begin
              idx_d  = idx_q + 4'd1;
              half_d = 4'd0;
              len_d  = '0;
              pol_d  = 1'b1;
            end else begin
              state_d = c_GAP;
              gap_d   = '0;
            end
          end
        end
        c_GAP: begin
          if (gap_q == c_GAP_LAST) begin
            state_d = c_PLAY;
            idx_d   = idx_q + 4'd1;
            half_d  = 4'd0;
            len_d   = '0;
            gap_d   = '0;
            pol_d   = 1'b1;
          end else begin
            gap_d = gap_q + c_ONE;
          end
        end
        default: ;
      endcase
    end
  end

  // Output logic: sample is decoded from registered state so it is stable
  // for the whole cycle in which the codec accepts it.
  always_comb begin
    write  = accept;
    busy   = (state_q != c_IDLE);
    effect = effect_q;
    sample = 24'd0;
    if (state_q == c_PLAY) begin
      sample = pol_q ? c_POS : c_NEG;
    end
  end

endmodule
`default_nettype wire
